// File: rtl/pci_wrr_arbiter.sv
// Weighted round-robin PCI bus arbiter with grant timeout.
// Optional bus parking on the last owner is enabled by defining PCI_ARB_PARK_EN.
module pci_wrr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int WEIGHT_W = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         req,
    input  logic                        frame,
    input  logic                        wt_wr_en,
    input  logic [$clog2(CHANNELS)-1:0] wt_wr_idx,
    input  logic [WEIGHT_W-1:0]         wt_wr_data,
    output logic [CHANNELS-1:0]         grnt,
    output logic [$clog2(CHANNELS)-1:0] owner,
    output logic                        busy,
    output logic                        timeout
);

    localparam int                IDX_W    = $clog2(CHANNELS);
    localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [CHANNELS-1:0] ONE    = CHANNELS'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT,
        ST_XFER,
        ST_TURN
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CHANNELS-1:0]  grnt_q;
    logic [CHANNELS-1:0]  grnt_d;
    logic [IDX_W-1:0]     owner_q;
    logic                 timeout_q;
    logic [7:0]           wait_cnt;
    logic [WEIGHT_W-1:0]  weight_q [CHANNELS];
    logic [WEIGHT_W-1:0]  credit_q [CHANNELS];

    logic [CHANNELS-1:0]  eligible;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic [CHANNELS-1:0]  park_grnt;
    logic                 do_grant;
    logic                 do_reload;
    logic                 do_revoke;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            eligible[i] = req[i] && (credit_q[i] != '0);
        end
    end

    // Scan starts one past the current owner and wraps, so the owner is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = IDX_W'((int'(owner_q) + k) % CHANNELS);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef PCI_ARB_PARK_EN
    assign park_grnt = (req == '0) ? (ONE << owner_q) : '0;
`else
    assign park_grnt = '0;
`endif

    always_comb begin
        state_d   = state_q;
        grnt_d    = grnt_q;
        do_grant  = 1'b0;
        do_reload = 1'b0;
        do_revoke = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d  = ST_GRANT;
                    grnt_d   = ONE << win_idx;
                    do_grant = 1'b1;
                end else begin
                    grnt_d    = park_grnt;
                    do_reload = (req != '0);
                end
            end
            ST_GRANT: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (frame) begin
                    state_d = ST_XFER;
                end else if (wait_cnt == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    grnt_d    = '0;
                    do_revoke = 1'b1;
                end
            end
            ST_XFER: begin
                if (!frame) begin
                    state_d = ST_TURN;
                    grnt_d  = '0;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
                grnt_d  = park_grnt;
            end
            default: begin
                state_d = ST_IDLE;
                grnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A reload reads the weight registers before a same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            grnt_q    <= '0;
            owner_q   <= '0;
            timeout_q <= 1'b0;
            wait_cnt  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                weight_q[i] <= WEIGHT_W'(1);
                credit_q[i] <= WEIGHT_W'(1);
            end
        end else begin
            grnt_q    <= grnt_d;
            timeout_q <= do_revoke;
            if (do_grant) begin
                owner_q           <= win_idx;
                credit_q[win_idx] <= credit_q[win_idx] - WEIGHT_W'(1);
            end
            if (do_reload) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    credit_q[i] <= weight_q[i];
                end
            end
            if (state_q == ST_GRANT) begin
                wait_cnt <= '0;
            end else if (state_q == ST_WAIT && wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (wt_wr_en && int'(wt_wr_idx) < CHANNELS) begin
                weight_q[wt_wr_idx] <= (wt_wr_data == '0) ? WEIGHT_W'(1) : wt_wr_data;
            end
        end
    end

    assign grnt    = grnt_q;
    assign owner   = owner_q;
    assign timeout = timeout_q;
    assign busy    = (state_q == ST_GRANT) || (state_q == ST_WAIT) || (state_q == ST_XFER);

endmodule

// File: tb/tb_pci_wrr_arbiter.sv
// Directed testbench for pci_wrr_arbiter with hand-computed grant sequences.
// Covers round-robin, weights, timeout, frame-at-deadline, mid-transfer reset and parking.
module tb_pci_wrr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       frame;
    logic       wt_wr_en;
    logic [1:0] wt_wr_idx;
    logic [3:0] wt_wr_data;
    logic [3:0] grnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int tests_run    = 0;
    int tests_failed = 0;
    int seq_b [12]   = '{1, 2, 3, 0, -1, 1, 2, 3, 0, 0, 0, -1};
    int last_owner;

    pci_wrr_arbiter #(
        .CHANNELS (4),
        .WEIGHT_W (4),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .frame      (frame),
        .wt_wr_en   (wt_wr_en),
        .wt_wr_idx  (wt_wr_idx),
        .wt_wr_data (wt_wr_data),
        .grnt       (grnt),
        .owner      (owner),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] onehot(input int idx);
        return 4'b0001 << idx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic f);
        req   = r;
        frame = f;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_grnt,
                               input logic [1:0] exp_owner, input logic exp_busy,
                               input logic exp_timeout);
        tests_run++;
        assert (grnt === exp_grnt) else begin
            tests_failed++;
            $error("[TB] FAIL %s grnt: got %b expected %b", tag, grnt, exp_grnt);
        end
        tests_run++;
        assert (owner === exp_owner) else begin
            tests_failed++;
            $error("[TB] FAIL %s owner: got %0d expected %0d", tag, owner, exp_owner);
        end
        tests_run++;
        assert (busy === exp_busy) else begin
            tests_failed++;
            $error("[TB] FAIL %s busy: got %b expected %b", tag, busy, exp_busy);
        end
        tests_run++;
        assert (timeout === exp_timeout) else begin
            tests_failed++;
            $error("[TB] FAIL %s timeout: got %b expected %b", tag, timeout, exp_timeout);
        end
    endtask

    task automatic doReset();
        rst      = 1'b1;
        wt_wr_en = 1'b0;
        wt_wr_idx  = '0;
        wt_wr_data = '0;
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();
        checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic checkGrant(input string tag, input int idx);
        tick();
        checkOutput(tag, onehot(idx), 2'(idx), 1'b1, 1'b0);
    endtask

    task automatic xfer2(input string tag, input int idx);
        tick();
        frame = 1'b1;
        tick();
        tick();
        checkOutput({tag, "_xfer"}, onehot(idx), 2'(idx), 1'b1, 1'b0);
        frame = 1'b0;
        tick();
        checkOutput({tag, "_turn"}, 4'b0000, 2'(idx), 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        // Plain round-robin between ch0 and ch2; the scan starts at ch1 after reset.
        doReset();
        applyStimulus(4'b0101, 1'b0);
        checkGrant("a_g1", 2);
        xfer2("a_g1", 2);
        checkGrant("a_g2", 0);
        xfer2("a_g2", 0);
        tick();
        checkOutput("a_reload", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkGrant("a_g3", 2);
        xfer2("a_g3", 2);
        checkGrant("a_g4", 0);
        xfer2("a_g4", 0);

        // Weights {3,1,1,1}; ch1 is written as 0 and must behave as 1.
        doReset();
        wt_wr_en   = 1'b1;
        wt_wr_idx  = 2'd0;
        wt_wr_data = 4'd3;
        tick();
        wt_wr_idx  = 2'd1;
        wt_wr_data = 4'd0;
        tick();
        wt_wr_en = 1'b0;
        applyStimulus(4'b1111, 1'b0);
        last_owner = 0;
        for (int i = 0; i < 12; i++) begin
            if (seq_b[i] < 0) begin
                tick();
                checkOutput($sformatf("b_reload%0d", i), 4'b0000, 2'(last_owner), 1'b0, 1'b0);
            end else begin
                checkGrant($sformatf("b_step%0d", i), seq_b[i]);
                xfer2($sformatf("b_step%0d", i), seq_b[i]);
                last_owner = seq_b[i];
            end
        end

        // ch1 never raises frame: revoked after 16 WAIT cycles, then ch3 wins.
        doReset();
        applyStimulus(4'b0010, 1'b0);
        checkGrant("c_g1", 1);
        tick();
        repeat (15) tick();
        checkOutput("c_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        checkOutput("c_revoke", 4'b0000, 2'd1, 1'b0, 1'b1);
        applyStimulus(4'b1010, 1'b0);
        tick();
        checkOutput("c_next", 4'b1000, 2'd3, 1'b1, 1'b0);
        xfer2("c_next", 3);

        // frame rises on the last allowed WAIT cycle and wins over the timeout.
        doReset();
        applyStimulus(4'b0010, 1'b0);
        checkGrant("d_g1", 1);
        tick();
        repeat (15) tick();
        frame = 1'b1;
        tick();
        checkOutput("d_xfer", 4'b0010, 2'd1, 1'b1, 1'b0);
        frame = 1'b0;
        tick();
        checkOutput("d_turn", 4'b0000, 2'd1, 1'b0, 1'b0);
        tick();

        // Reset in the middle of a transfer, then a fresh grant with reset latency.
        doReset();
        applyStimulus(4'b0100, 1'b0);
        checkGrant("e_g1", 2);
        tick();
        frame = 1'b1;
        tick();
        checkOutput("e_in_xfer", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("e_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst   = 1'b0;
        frame = 1'b0;
        checkGrant("e_g2", 2);
        xfer2("e_g2", 2);

`ifdef PCI_ARB_PARK_EN
        // Grant parks on ch3 once idle, then moves straight to ch1.
        doReset();
        applyStimulus(4'b1000, 1'b0);
        checkGrant("p_g3", 3);
        tick();
        frame = 1'b1;
        tick();
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("p_turn", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick();
        checkOutput("p_park", 4'b1000, 2'd3, 1'b0, 1'b0);
        tick();
        checkOutput("p_park2", 4'b1000, 2'd3, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        tick();
        checkOutput("p_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
